latch_bank_writer: RTL and testbench

Write initiator for a bank of level-sensitive D-latches. It accepts one write request at a time over a valid/ready handshake. For each request it drives the shared data bus and the one-hot latch enables with guaranteed setup, pulse and hold cycles. The data bus is stable for the whole time any enable is high, so latches never capture a changing value. It sits between the control logic and the latch array.

---
 rtl/latch_bank_writer.sv | 187 ++++++++++++++++++
 tb/tb_latch_bank_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_writer.sv
// rtl/latch_bank_writer.sv - write sequencer for a bank of D-latches (setup/pulse/hold); optional readback via LATCH_BANK_VERIFY_EN
module latch_bank_writer #(
    parameter int N_LATCH   = 8,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 1,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    output logic [N_LATCH-1:0]        lat_en,
    output logic [DATA_W-1:0]         lat_d,
    input  logic [N_LATCH*DATA_W-1:0] lat_q,
    output logic                      busy,
    output logic                      done,
    output logic                      addr_err,
    output logic                      vfy_err
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]   N_LATCH_L = (ADDR_W + 1)'(N_LATCH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_VERIFY
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [ADDR_W-1:0]   addr_r, addr_next;
    logic [DATA_W-1:0]   data_r, data_next;
    logic                oor_r, oor_next;
    logic [N_LATCH-1:0]  lat_en_next, en_dec;
    logic [DATA_W-1:0]   lat_d_next;
    logic                done_next, addr_err_next, vfy_err_next;

    // An out-of-range address matches no index, so the decode is naturally all-zero.
    always_comb begin
        en_dec = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (addr_r == ADDR_W'(i)) begin
                en_dec[i] = 1'b1;
            end
        end
    end

`ifdef LATCH_BANK_VERIFY_EN
    logic [DATA_W-1:0] q_sel;

    always_comb begin
        q_sel = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (addr_r == ADDR_W'(i)) begin
                q_sel = lat_q[i*DATA_W +: DATA_W];
            end
        end
    end
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q;
`endif

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        addr_next     = addr_r;
        data_next     = data_r;
        oor_next      = oor_r;
        lat_en_next   = '0;
        lat_d_next    = lat_d;
        done_next     = 1'b0;
        addr_err_next = 1'b0;
        vfy_err_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LD;
                    addr_next  = req_addr;
                    data_next  = req_data;
                    oor_next   = ({1'b0, req_addr} >= N_LATCH_L);
                    lat_d_next = req_data;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next  = ST_PULSE;
                    cnt_next    = PULSE_LD;
                    lat_en_next = en_dec;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next    = cnt - 1'b1;
                    lat_en_next = en_dec;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
`ifdef LATCH_BANK_VERIFY_EN
                    state_next = ST_VERIFY;
                    cnt_next   = '0;
`else
                    state_next    = ST_IDLE;
                    done_next     = 1'b1;
                    addr_err_next = oor_r;
`endif
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
`ifdef LATCH_BANK_VERIFY_EN
            ST_VERIFY: begin
                state_next    = ST_IDLE;
                done_next     = 1'b1;
                addr_err_next = oor_r;
                vfy_err_next  = !oor_r && (q_sel != data_r);
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            oor_r    <= 1'b0;
            lat_en   <= '0;
            lat_d    <= '0;
            done     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            addr_r   <= addr_next;
            data_r   <= data_next;
            oor_r    <= oor_next;
            lat_en   <= lat_en_next;
            lat_d    <= lat_d_next;
            done     <= done_next;
            addr_err <= addr_err_next;
        end
    end

`ifdef LATCH_BANK_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vfy_err <= 1'b0;
        end else begin
            vfy_err <= vfy_err_next;
        end
    end
`else
    logic unused_vfy_next;
    assign unused_vfy_next = vfy_err_next;
    assign vfy_err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// tb/tb_latch_bank_writer.sv - self-checking bench for latch_bank_writer (N_LATCH=8, ADDR_W=4)
module tb_latch_bank_writer;

    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
`ifdef LATCH_BANK_VERIFY_EN
    localparam int TOTAL = S + P + H + 1;
    localparam bit VFY   = 1'b1;
`else
    localparam int TOTAL = S + P + H;
    localparam bit VFY   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_addr = '0;
    logic [0:0] req_data = '0;
    logic [7:0] lat_en;
    logic [0:0] lat_d;
    logic [7:0] lat_q;
    logic       busy, done, addr_err, vfy_err;

    logic [7:0] latch_bits = '0;
    logic [7:0] flip_mask = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latch_bank_writer #(
        .N_LATCH(8), .ADDR_W(4), .DATA_W(1),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .lat_en(lat_en), .lat_d(lat_d), .lat_q(lat_q),
        .busy(busy), .done(done), .addr_err(addr_err), .vfy_err(vfy_err)
    );

    // Behavioural latch array; flip_mask injects readback corruption.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (lat_en[i]) latch_bits[i] <= lat_d[0];
        end
    end
    assign lat_q = latch_bits ^ flip_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] addr;
        logic       data;
        logic [7:0] exp_en;
        logic       exp_ae;
    } vec_t;

    // One complete write from idle; inputs are scrambled while busy.
    task automatic do_write(input logic [3:0] a, input logic d, input logic [7:0] exp_en,
                            input logic exp_ae, input logic exp_ve);
        @(negedge clk);
        chk("pre_ready", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_data = d;
        for (int p = 1; p <= TOTAL + 1; p++) begin
            @(negedge clk);
            chk("w_ready", req_ready, (p > TOTAL));
            chk("w_busy", busy, (p <= TOTAL));
            chk("w_lat_en", lat_en, (p > S && p <= S + P) ? exp_en : 8'h00);
            chk("w_lat_d", lat_d, d);
            chk("w_done", done, (p == TOTAL + 1));
            chk("w_addr_err", addr_err, (p == TOTAL + 1) && exp_ae);
            chk("w_vfy_err", vfy_err, (p == TOTAL + 1) && exp_ve);
            req_valid = (p <= TOTAL) ? ($urandom_range(0, 1) == 1) : 1'b0;
            req_addr  = 4'($urandom);
            req_data  = 1'($urandom);
        end
        req_valid = 1'b0;
    endtask

    vec_t vecs[6];
    int   p, n80, n01;
    logic [3:0] m_addr;
    logic       m_d;
    logic [7:0] m_flip;
    logic       seen;

    initial begin
        vecs[0] = '{4'd3,  1'b1, 8'h08, 1'b0};
        vecs[1] = '{4'd0,  1'b1, 8'h01, 1'b0};
        vecs[2] = '{4'd7,  1'b0, 8'h80, 1'b0};
        vecs[3] = '{4'd9,  1'b1, 8'h00, 1'b1};
        vecs[4] = '{4'd8,  1'b0, 8'h00, 1'b1};
        vecs[5] = '{4'd15, 1'b1, 8'h00, 1'b1};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_lat_en", lat_en, 0);
        chk("rst_done", done, 0);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_en, vecs[i].exp_ae, 1'b0);
        end

        // Back-to-back: second request accepted in the done cycle.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 4'd0; req_data = 1'b1;
        n01 = 0;
        for (int q = 1; q <= TOTAL + 1; q++) begin
            @(negedge clk);
            if (lat_en == 8'h01) n01++;
            if (q == 1) begin
                req_addr = 4'd7; req_data = 1'b0;
            end
            if (q == TOTAL + 1) begin
                chk("b2b_done", done, 1);
                chk("b2b_ready", req_ready, 1);
                chk("b2b_lat_d_hold", lat_d, 1);
            end
        end
        chk("b2b_en01_cycles", n01, P);
        n80 = 0;
        for (int q = 1; q <= TOTAL + 1; q++) begin
            @(negedge clk);
            if (q == 1) begin
                req_valid = 1'b0;
                chk("b2b_setup_lat_d", lat_d, 0);
                chk("b2b_setup_busy", busy, 1);
                chk("b2b_setup_en", lat_en, 0);
            end
            if (lat_en == 8'h80) n80++;
            if (q == TOTAL + 1) chk("b2b_done2", done, 1);
        end
        chk("b2b_en80_cycles", n80, P);

`ifdef LATCH_BANK_VERIFY_EN
        flip_mask = 8'h04;
        do_write(4'd2, 1'b1, 8'h04, 1'b0, 1'b1);
        flip_mask = 8'h00;
        do_write(4'd2, 1'b1, 8'h04, 1'b0, 1'b0);
        flip_mask = 8'hFF;
        do_write(4'd9, 1'b1, 8'h00, 1'b1, 1'b0);
        flip_mask = 8'h00;
`endif

        // Asynchronous reset in the middle of a pulse.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 4'd2; req_data = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (lat_en == 8'h04) seen = 1'b1;
        end
        chk("rst_pulse_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_lat_en", lat_en, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ready", req_ready, 1);
        chk("rst2_busy", busy, 0);
        chk("rst2_lat_d", lat_d, 0);
        chk("rst2_done", done, 0);

        // Random traffic against a phase-position model.
        p = TOTAL + 2; m_addr = '0; m_d = 1'b0; m_flip = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk("r_busy", busy, (p >= 1 && p <= TOTAL));
            chk("r_ready", req_ready, !(p >= 1 && p <= TOTAL));
            chk("r_lat_en", lat_en,
                (p > S && p <= S + P && m_addr < 8) ? (8'h01 << m_addr) : 8'h00);
            chk("r_lat_d", lat_d, m_d);
            chk("r_done", done, (p == TOTAL + 1));
            chk("r_addr_err", addr_err, (p == TOTAL + 1) && (m_addr >= 8));
            chk("r_vfy_err", vfy_err,
                (p == TOTAL + 1) && VFY && (m_addr < 8) && m_flip[m_addr[2:0]]);
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = 4'($urandom);
            req_data  = 1'($urandom);
            if (!(p >= 1 && p <= TOTAL) && req_valid) begin
                p = 1; m_addr = req_addr; m_d = req_data;
                m_flip = 8'($urandom);
                flip_mask = m_flip;
            end else if (p <= TOTAL + 1) begin
                p++;
            end
        end
        req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
